// File: rtl/qam_symbol_scheduler.sv
// Framed QAM symbol sequencer: preamble, N data symbols, then a guard gap.
// Optional pilot insertion is enabled with the SCHED_PILOT_EN macro.
module qam_symbol_scheduler #(
  parameter int         PERIOD_W     = 16,
  parameter int         PREAMBLE_LEN = 8,
  parameter logic [3:0] PREAMBLE_A   = 4'h0,
  parameter logic [3:0] PREAMBLE_B   = 4'hF,
  parameter logic [3:0] IDLE_SYMBOL  = 4'h5,
  parameter int         GAP_SYMBOLS  = 4
`ifdef SCHED_PILOT_EN
  ,
  parameter logic [3:0] PILOT_SYMBOL   = 4'hA,
  parameter int         PILOT_INTERVAL = 16
`endif
) (
  input  logic                ipClk,
  input  logic                ipReset,
  input  logic                ipEnable,
  input  logic [PERIOD_W-1:0] ipSymbolPeriod,
  input  logic [PERIOD_W-1:0] ipBurstLength,
  input  logic [3:0]          ipSymbol,
  input  logic                ipSymbolValid,
  output logic                opSymbolReady,
  output logic [3:0]          opQAMBlock,
  output logic                opQAMBlockValid,
  output logic [1:0]          opState,
  output logic                opBusy,
  output logic [15:0]         opUnderflowCount,
  output logic [15:0]         opBurstCount
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    GAP      = 2'd3
  } stateT;

  stateT               state, stateN;
  logic [PERIOD_W-1:0] tick, tickN;
  logic [PERIOD_W-1:0] period, periodN;
  logic [PERIOD_W-1:0] burstLen, burstLenN;
  logic [PERIOD_W-1:0] phase, phaseN;
  logic [PERIOD_W-1:0] dataCnt, dataCntN;
  logic [3:0]          qamBlock, qamBlockN;
  logic                qamValid, qamValidN;
  logic [15:0]         underflowCnt, underflowCntN;
  logic [15:0]         burstCnt, burstCntN;
  logic [PERIOD_W-1:0] effPeriod;
  logic                strobe;
  logic                pilotDue;
  logic                lastData;

`ifdef SCHED_PILOT_EN
  logic [PERIOD_W-1:0] pilotCnt, pilotCntN;
  assign pilotDue = (pilotCnt == PERIOD_W'(PILOT_INTERVAL));
`else
  assign pilotDue = 1'b0;
`endif

  assign effPeriod = (ipSymbolPeriod < PERIOD_W'(2)) ? PERIOD_W'(2) : ipSymbolPeriod;
  assign strobe    = (state != IDLE) && (tick == (period - PERIOD_W'(1)));

  // Pop is combinational so the FIFO advances on the very edge that captures its head.
  assign opSymbolReady    = (state == DATA) && strobe && ipSymbolValid && !pilotDue && !ipReset;
  assign opQAMBlock       = qamBlock;
  assign opQAMBlockValid  = qamValid;
  assign opState          = state;
  assign opBusy           = (state != IDLE);
  assign opUnderflowCount = underflowCnt;
  assign opBurstCount     = burstCnt;

  // Next-state, symbol selection and counter updates.
  always_comb begin
    stateN        = state;
    periodN       = period;
    burstLenN     = burstLen;
    phaseN        = phase;
    dataCntN      = dataCnt;
    qamBlockN     = qamBlock;
    qamValidN     = 1'b0;
    underflowCntN = underflowCnt;
    burstCntN     = burstCnt;
    lastData      = 1'b0;
`ifdef SCHED_PILOT_EN
    pilotCntN     = pilotCnt;
`endif

    if (state == IDLE || strobe) begin
      tickN = PERIOD_W'(0);
    end else begin
      tickN = tick + PERIOD_W'(1);
    end

    case (state)
      IDLE: begin
        if (ipEnable && ipSymbolValid) begin
          stateN    = PREAMBLE;
          periodN   = effPeriod;
          burstLenN = ipBurstLength;
          phaseN    = PERIOD_W'(0);
          dataCntN  = PERIOD_W'(0);
`ifdef SCHED_PILOT_EN
          pilotCntN = PERIOD_W'(0);
`endif
        end else begin
          stateN = IDLE;
        end
      end
      PREAMBLE: begin
        if (strobe) begin
          qamValidN = 1'b1;
          qamBlockN = phase[0] ? PREAMBLE_B : PREAMBLE_A;
          if (phase == PERIOD_W'(PREAMBLE_LEN - 1)) begin
            stateN = DATA;
            phaseN = PERIOD_W'(0);
          end else begin
            phaseN = phase + PERIOD_W'(1);
          end
        end else begin
          stateN = PREAMBLE;
        end
      end
      DATA: begin
        if (strobe) begin
          qamValidN = 1'b1;
          if (pilotDue) begin
`ifdef SCHED_PILOT_EN
            qamBlockN = PILOT_SYMBOL;
            pilotCntN = PERIOD_W'(0);
`endif
          end else begin
            if (ipSymbolValid) begin
              qamBlockN = ipSymbol;
            end else begin
              qamBlockN = IDLE_SYMBOL;
              if (underflowCnt != 16'hFFFF) begin
                underflowCntN = underflowCnt + 16'd1;
              end else begin
                underflowCntN = underflowCnt;
              end
            end
            dataCntN = dataCnt + PERIOD_W'(1);
`ifdef SCHED_PILOT_EN
            pilotCntN = pilotCnt + PERIOD_W'(1);
`endif
            lastData = (burstLen != PERIOD_W'(0)) && ((dataCnt + PERIOD_W'(1)) == burstLen);
          end
          // A disable still lets the current boundary emit its symbol.
          if (lastData || !ipEnable) begin
            stateN = GAP;
            phaseN = PERIOD_W'(0);
          end else begin
            stateN = DATA;
          end
        end else begin
          stateN = DATA;
        end
      end
      GAP: begin
        if (strobe) begin
          if (phase == PERIOD_W'(GAP_SYMBOLS - 1)) begin
            stateN    = IDLE;
            phaseN    = PERIOD_W'(0);
            burstCntN = burstCnt + 16'd1;
          end else begin
            phaseN = phase + PERIOD_W'(1);
          end
        end else begin
          stateN = GAP;
        end
      end
      default: begin
        stateN = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state        <= IDLE;
      tick         <= PERIOD_W'(0);
      period       <= PERIOD_W'(2);
      burstLen     <= PERIOD_W'(0);
      phase        <= PERIOD_W'(0);
      dataCnt      <= PERIOD_W'(0);
      qamBlock     <= 4'h0;
      qamValid     <= 1'b0;
      underflowCnt <= 16'd0;
      burstCnt     <= 16'd0;
`ifdef SCHED_PILOT_EN
      pilotCnt     <= PERIOD_W'(0);
`endif
    end else begin
      state        <= stateN;
      tick         <= tickN;
      period       <= periodN;
      burstLen     <= burstLenN;
      phase        <= phaseN;
      dataCnt      <= dataCntN;
      qamBlock     <= qamBlockN;
      qamValid     <= qamValidN;
      underflowCnt <= underflowCntN;
      burstCnt     <= burstCntN;
`ifdef SCHED_PILOT_EN
      pilotCnt     <= pilotCntN;
`endif
    end
  end

endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// Scoreboard bench for qam_symbol_scheduler: burst model builds expected symbol
// streams, a forked monitor compares every emitted strobe against them.
module tb_qam_symbol_scheduler;

  localparam int         PRE_LEN   = 8;
  localparam int         GAP_SYMS  = 4;
  localparam logic [3:0] PRE_A     = 4'h0;
  localparam logic [3:0] PRE_B     = 4'hF;
  localparam logic [3:0] IDLE_SYM  = 4'h5;
`ifdef SCHED_PILOT_EN
  localparam int         PILOT_INT = 2;
  localparam logic [3:0] PILOT_SYM = 4'hA;
`endif

  logic        ipClk = 1'b0;
  logic        ipReset;
  logic        ipEnable;
  logic [15:0] ipSymbolPeriod;
  logic [15:0] ipBurstLength;
  logic [3:0]  ipSymbol;
  logic        ipSymbolValid;
  logic        opSymbolReady;
  logic [3:0]  opQAMBlock;
  logic        opQAMBlockValid;
  logic [1:0]  opState;
  logic        opBusy;
  logic [15:0] opUnderflowCount;
  logic [15:0] opBurstCount;

  qam_symbol_scheduler #(
    .PERIOD_W(16)
`ifdef SCHED_PILOT_EN
    , .PILOT_INTERVAL(PILOT_INT)
`endif
  ) dut (
    .ipClk(ipClk), .ipReset(ipReset), .ipEnable(ipEnable),
    .ipSymbolPeriod(ipSymbolPeriod), .ipBurstLength(ipBurstLength),
    .ipSymbol(ipSymbol), .ipSymbolValid(ipSymbolValid),
    .opSymbolReady(opSymbolReady), .opQAMBlock(opQAMBlock),
    .opQAMBlockValid(opQAMBlockValid), .opState(opState), .opBusy(opBusy),
    .opUnderflowCount(opUnderflowCount), .opBurstCount(opBurstCount)
  );

  always #5 ipClk = ~ipClk;

  // FIFO model: a ring of symbols with read/write pointers.
  logic [3:0] fifoMem [0:255];
  int rdPtr = 0;
  int wrPtr = 0;
  assign ipSymbolValid = (rdPtr != wrPtr);
  assign ipSymbol      = fifoMem[rdPtr[7:0]];

  typedef struct {
    logic [3:0] sym;
    int         spacing;
  } expT;
  expT expQ[$];

  int  checks = 0;
  int  passes = 0;
  int  popCount = 0;
  int  expUnderflow = 0;
  int  expBursts = 0;
  bit  firstPush;
  time lastStrobeTime = 0;
  logic [1:0] sState;
  logic       sBusy;
  logic       sReady;
  time        sTime;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic step();
    @(negedge ipClk);
    sState = opState;
    sBusy  = opBusy;
    sReady = opSymbolReady;
    sTime  = $time;
    @(posedge ipClk);
    #1;
    if (sReady) begin
      rdPtr++;
      popCount++;
    end
  endtask

  task automatic pushExp(input logic [3:0] sym, input int per);
    expQ.push_back('{sym: sym, spacing: (firstPush ? 0 : per)});
    firstPush = 1'b0;
  endtask

  // Expected stream for one burst: preamble, then data/underflow/pilot symbols.
  task automatic buildExp(input logic [3:0] items[$], input int len, input int maxData,
                          input int per, output int nPops);
    int d = 0;
    int e = 0;
    int since = 0;
    firstPush = 1'b1;
    for (int k = 0; k < PRE_LEN; k++) pushExp((k % 2 == 1) ? PRE_B : PRE_A, per);
    while ((len != 0 && d < len) || (len == 0 && e < maxData)) begin
`ifdef SCHED_PILOT_EN
      if (since == PILOT_INT) begin
        pushExp(PILOT_SYM, per);
        since = 0;
        e++;
        continue;
      end
`endif
      if (d < items.size()) pushExp(items[d], per);
      else begin
        pushExp(IDLE_SYM, per);
        expUnderflow++;
      end
      d++;
      since++;
      e++;
    end
    nPops = (d < items.size()) ? d : items.size();
  endtask

  task automatic loadFifo(input int n, input bit fixedData, output logic [3:0] items[$]);
    items = {};
    for (int i = 0; i < n; i++) begin
      items.push_back(fixedData ? 4'(i + 1) : 4'($urandom_range(15, 0)));
      fifoMem[wrPtr[7:0]] = items[i];
      wrPtr++;
    end
  endtask

  task automatic waitDrain(input int minLeft);
    int n = 0;
    while (expQ.size() > minLeft && n < 4000) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(expQ.size() > minLeft), 32'd0);
  endtask

  task automatic waitIdle(input int effP, input int popsReq, input int popsBase);
    int n = 0;
    step();
    while (sState != 2'd0 && n < 1000) begin
      step();
      n++;
    end
    chk("idle_timeout", 32'(sState), 32'd0);
    chk("gap_cycles", 32'((sTime - lastStrobeTime) / 10), 32'(GAP_SYMS * effP));
    chk("busy_idle", 32'(sBusy), 32'd0);
    chk("pops", 32'(popCount - popsBase), 32'(popsReq));
    chk("burst_count", 32'(opBurstCount), 32'(expBursts));
    chk("underflow_count", 32'(opUnderflowCount), 32'(expUnderflow));
  endtask

  task automatic runBurst(input int per, input int len, input int nItems,
                          input int newPer, input bit fixedData);
    logic [3:0] items[$];
    int effP;
    int nPops;
    int base;
    effP = (per < 2) ? 2 : per;
    loadFifo(nItems, fixedData, items);
    buildExp(items, len, 0, effP, nPops);
    base = popCount;
    ipSymbolPeriod = 16'(per);
    ipBurstLength  = 16'(len);
    ipEnable       = 1'b1;
    step();
    step();
    ipSymbolPeriod = 16'(newPer);
    ipBurstLength  = 16'($urandom_range(9, 1));
    waitDrain(0);
    expBursts++;
    waitIdle(effP, nPops, base);
    ipEnable = 1'b0;
  endtask

  initial begin
    logic [3:0] items[$];
    int nPops;
    int base;

    fork
      // Monitor: every strobe pops one expectation and checks value and spacing.
      forever begin
        expT e;
        @(negedge ipClk);
        if (opQAMBlockValid === 1'b1) begin
          if (expQ.size() == 0) begin
            chk("unexpected_strobe", 32'(opQAMBlock), 32'hDEAD);
          end else begin
            e = expQ.pop_front();
            chk("symbol", 32'(opQAMBlock), 32'(e.sym));
            if (e.spacing != 0) chk("spacing", 32'(($time - lastStrobeTime) / 10), 32'(e.spacing));
          end
          lastStrobeTime = $time;
        end
      end
    join_none

    ipReset = 1'b1;
    ipEnable = 1'b0;
    ipSymbolPeriod = 16'd4;
    ipBurstLength = 16'd3;
    step();
    step();
    ipReset = 1'b0;
    chk("rst_state", 32'(opState), 32'd0);
    chk("rst_block", 32'(opQAMBlock), 32'd0);
    chk("rst_valid", 32'(opQAMBlockValid), 32'd0);
    chk("rst_ready", 32'(opSymbolReady), 32'd0);
    chk("rst_busy", 32'(opBusy), 32'd0);
    chk("rst_underflow", 32'(opUnderflowCount), 32'd0);
    chk("rst_bursts", 32'(opBurstCount), 32'd0);

    runBurst(4, 3, 3, 7, 1'b1);              // basic burst 1,2,3
    runBurst(2, 4, 2, 5, 1'b0);              // underflow: two idle symbols
    runBurst(0, 5, 5, 8, 1'b0);              // clamped period, change ignored
    runBurst(1, 4, 4, 0, 1'b1);              // 4 data symbols (pilot case too)

    // Continuous mode: drop enable mid-period after ten DATA-phase symbols.
    loadFifo(12, 1'b0, items);
    buildExp(items, 0, 11, 3, nPops);
    base = popCount;
    ipSymbolPeriod = 16'd3;
    ipBurstLength  = 16'd0;
    ipEnable       = 1'b1;
    waitDrain(1);
    ipEnable = 1'b0;
    waitDrain(0);
    expBursts++;
    waitIdle(3, nPops, base);
    rdPtr = wrPtr;

    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(6, 1);
      runBurst($urandom_range(5, 0), len, $urandom_range(len, 1), $urandom_range(15, 0), 1'b0);
    end

    // Reset mid-DATA, landing on a boundary where the FIFO would be popped.
    loadFifo(6, 1'b0, items);
    buildExp(items, 6, 0, 2, nPops);
    ipSymbolPeriod = 16'd2;
    ipBurstLength  = 16'd6;
    ipEnable       = 1'b1;
    waitDrain(PRE_LEN + 6 - 2 + ((expQ.size() > PRE_LEN + 6) ? 1 : 0));
    base = popCount;
    ipReset = 1'b1;
    step();
    ipReset = 1'b0;
    ipEnable = 1'b0;
    chk("mid_rst_ready", 32'(sReady), 32'd0);
    chk("mid_rst_pops", 32'(popCount - base), 32'd0);
    chk("mid_rst_state", 32'(opState), 32'd0);
    chk("mid_rst_block", 32'(opQAMBlock), 32'd0);
    chk("mid_rst_valid", 32'(opQAMBlockValid), 32'd0);
    chk("mid_rst_underflow", 32'(opUnderflowCount), 32'd0);
    chk("mid_rst_bursts", 32'(opBurstCount), 32'd0);
    chk("mid_rst_ready_after", 32'(opSymbolReady), 32'd0);
    expQ.delete();
    rdPtr = wrPtr;
    expUnderflow = 0;
    expBursts = 0;
    step();

    runBurst(3, 3, 1, 2, 1'b0);              // counters restart from zero
    runBurst(2, 2, 2, 9, 1'b0);

    step();
    chk("leftover_expect", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/qam_symbol_scheduler.md
Name: qam_symbol_scheduler

Overview:
- Sequences 4-bit QAM symbols from the streamer FIFO into the QAM modulator at a programmable symbol rate, in framed bursts.
- A burst is a fixed preamble, then N data symbols, then a guard gap.
- Sits between the Streamer's QAM block output and the QAM modulator input.
- Configuration comes from the register bank. Status goes back to the register bank for readout.

Parameters:
- PERIOD_W, 16, width of the symbol-period and burst-length inputs and of the counters.
- PREAMBLE_LEN, 8, preamble symbols per burst (>=1).
- PREAMBLE_A, 4'h0, preamble symbol on even preamble indices.
- PREAMBLE_B, 4'hF, preamble symbol on odd preamble indices.
- IDLE_SYMBOL, 4'h5, symbol emitted on FIFO underflow.
- GAP_SYMBOLS, 4, guard periods after a burst with no output strobe.

Ports:
- ipClk  in  1  system clock.
- ipReset  in  1  synchronous reset, active-high.
- ipEnable  in  1  arms burst generation.
- ipSymbolPeriod  in  PERIOD_W  clocks per symbol; values 0 and 1 are treated as 2.
- ipBurstLength  in  PERIOD_W  data symbols per burst; 0 means continuous.
- ipSymbol  in  4  FIFO head symbol.
- ipSymbolValid  in  1  FIFO not empty.
- opSymbolReady  out  1  one-cycle pop strobe to the FIFO.
- opQAMBlock  out  4  symbol to the modulator; holds its value between strobes.
- opQAMBlockValid  out  1  one-cycle strobe per emitted symbol.
- opState  out  2  IDLE=0, PREAMBLE=1, DATA=2, GAP=3.
- opBusy  out  1  high when opState!=IDLE.
- opUnderflowCount  out  16  saturating count of underflow symbols.
- opBurstCount  out  16  completed bursts; wraps at 16 bits.

Behaviour:
- Reset: state IDLE and all counters 0. opQAMBlock=0, opQAMBlockValid=0, opSymbolReady=0, opUnderflowCount=0, opBurstCount=0.
- Tick counter:
  - Runs 0..P-1 in every non-IDLE state. P is the effective period latched at burst start.
  - Boundary strobe S = (tick==P-1).
  - The tick counter is held at 0 in IDLE.
- IDLE -> PREAMBLE: when ipEnable=1 and ipSymbolValid=1.
  - Latches P and the burst length L.
  - Clears the preamble and data indices.
  - Changes to these inputs mid-burst are ignored.
- PREAMBLE:
  - On each S, emits PREAMBLE_A (even index) or PREAMBLE_B (odd index).
  - After PREAMBLE_LEN symbols, goes to DATA.
- DATA, on each S:
  - If ipSymbolValid=1: opSymbolReady=1 in the same cycle (combinational from registered state/tick and ipSymbolValid) and ipSymbol is captured.
  - Otherwise: IDLE_SYMBOL is emitted and opUnderflowCount increments, saturating at 16'hFFFF.
  - Both cases count toward L.
  - opSymbolReady is never high outside the S cycle in DATA.
- Output latency: a symbol selected on cycle N drives opQAMBlock with opQAMBlockValid=1 on cycle N+1. This applies to preamble and data symbols alike.
- DATA -> GAP:
  - On the S that emits the L-th data symbol (L!=0).
  - Or on any S where ipEnable=0. That S still emits its symbol.
  - When L=0, DATA exits only via ipEnable=0.
- GAP:
  - Runs GAP_SYMBOLS periods with opQAMBlockValid=0.
  - Then opBurstCount increments and the state goes to IDLE.
  - ipEnable is ignored in GAP.
- ipEnable=0 during PREAMBLE: the preamble still completes, then DATA exits on its first S.
- Simultaneous events on the final GAP cycle: if ipEnable=1 and the FIFO is valid, the next burst starts on the following cycle from IDLE. There is at least one IDLE cycle between bursts.
- ipReset mid-burst: returns to IDLE next cycle and clears all outputs. The FIFO is not popped on the reset cycle.

Optional Feature:
- Macro: SCHED_PILOT_EN.
- When defined:
  - Adds parameters PILOT_SYMBOL (default 4'hA) and PILOT_INTERVAL (default 16).
  - In DATA, after every PILOT_INTERVAL data symbols, the next S emits PILOT_SYMBOL instead of a data symbol.
  - A pilot does not pop the FIFO, does not count toward L, and does not count as underflow.
  - The pilot counter resets at burst start.
- When undefined: no pilot logic, and the extra parameters are absent.

Test Plan:
- Basic burst:
  - Stimulus: P=4, L=3, FIFO holds 1,2,3, ipEnable=1.
  - Response: strobes every 4 cycles carrying 0,F,0,F,0,F,0,F,1,2,3.
  - Then 16 cycles with no strobe, IDLE, opBurstCount=1.
  - Exactly 3 opSymbolReady pulses.
- Underflow:
  - Stimulus: P=2, L=4, FIFO holds 2 symbols.
  - Response: data symbols are d0,d1,5,5; opUnderflowCount=2; opSymbolReady pulses only twice.
- Continuous mode and disable:
  - Stimulus: L=0, P=3; deassert ipEnable mid-period after 10 data symbols.
  - Response: the current symbol completes, then GAP, then IDLE; opBurstCount increments by 1.
- Period clamp and latching:
  - Stimulus: ipSymbolPeriod=0; then change it to 8 mid-burst.
  - Response: strobes every 2 cycles for the whole burst.
- Reset mid-DATA:
  - Stimulus: assert ipReset for 1 cycle.
  - Response: next cycle state=0, opQAMBlock=0, counters 0, no opSymbolReady.
- Pilots (SCHED_PILOT_EN):
  - Stimulus: PILOT_INTERVAL=2, L=4, data 1,2,3,4.
  - Response: data phase emits 1,2,A,3,4; 4 pops.
